// File: rtl/stream_max_argmax_if.sv
// Stream interface for stream_max_argmax: element input stream plus result output stream.
// master = producer/consumer side (testbench, upstream logic); slave = the reduction block.
interface stream_max_argmax_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [SIZE-1:0]  out_argmax;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_argmax
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_argmax
    );
endinterface

// File: rtl/stream_max_argmax.sv
// Serial max/argmax over frames of 2**SIZE unsigned elements.
// Ties resolve to the later index, matching the combinational tree.
module stream_max_argmax #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 2
) (
    input  logic                clk,
    input  logic                rst,
    stream_max_argmax_if.slave  stream
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] OUTPUT  = 1'b1;

    logic [0:0]       state;
    logic [SIZE-1:0]  cnt;
    logic [WIDTH-1:0] cur_max;
    logic [SIZE-1:0]  cur_arg;
    logic             accept;
    logic             handoff;

    // Handshake qualifiers; ready/valid come from registered state only
    always_comb begin
        accept  = stream.in_valid  && (state == COLLECT);
        handoff = stream.out_ready && (state == OUTPUT);
    end

    assign stream.in_ready   = (state == COLLECT);
    assign stream.out_valid  = (state == OUTPUT);
    assign stream.out_max    = cur_max;
    assign stream.out_argmax = cur_arg;

    // Frame collection, running max/argmax update and result handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            cnt     <= '0;
            cur_max <= '0;
            cur_arg <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            cur_max <= stream.in_data;
                            cur_arg <= '0;
                        end else if (stream.in_data >= cur_max) begin
                            cur_max <= stream.in_data;
                            cur_arg <= cnt;
                        end
                        if (cnt == '1) begin
                            state <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (handoff) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
